fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 19 +
 rtl/fetch_controller_branch_predecoder.sv | 36 +++
 rtl/fetch_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared constants for the fetch path: boolean levels, the opcodes the
// predecoder recognises, and the fetch controller state encoding.
package fetch_controller_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // FETCH: ready to issue; WAIT: one request outstanding;
    // DRAIN: a redirect orphaned the outstanding request, so its response is dropped.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_branch_predecoder.sv
// Static predictor: decodes JAL and conditional-branch immediates and picks
// the next fetch PC. Backward branches are predicted taken, forward ones not.
// JALR is not predicted because its target depends on a register.
module branch_predecoder
    import fetch_controller_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        predict
);

    logic [6:0]  opcode;
    logic [31:0] j_imm;
    logic [31:0] b_imm;

    assign opcode = instruction[6:0];
    assign j_imm  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
    assign b_imm  = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};

    // Choose the predicted successor; the sequential case wraps mod 2^32.
    always_comb begin
        next_pc = pc + 32'd4;
        predict = FALSE;
        if (opcode == OPC_JAL) begin
            next_pc = pc + j_imm;
            predict = TRUE;
        end else if (opcode == OPC_BRANCH && instruction[31]) begin
            next_pc = pc + b_imm;
            predict = TRUE;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: issues one icache request at a time, pushes each returned
// word with its PC and prediction bit into the instruction queue, and follows
// predicted control flow or mispredict redirects.
//
// Handshakes: icache_req is a one-cycle pulse carrying icache_addr, issued only
// when no request is outstanding; icache_ready is a one-cycle valid that
// qualifies icache_ins_in; instruction_ready is a one-cycle push with no
// backpressure -- the queue throttles us only through isq_is_full, which is
// sampled before a request is issued, so an accepted response always fits.
// rdy_in=0 freezes everything and masks icache_ready.
module fetch_controller
    import fetch_controller_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         roll_back,
    input  logic [31:0]  target_pc_in,
    input  logic         isq_is_full,
    output logic         icache_req,
    output logic [31:0]  icache_addr,
    input  logic         icache_ready,
    input  logic [31:0]  icache_ins_in,
    output logic         instruction_ready,
    output logic [31:0]  instruction_out,
    output logic [31:0]  pc_out,
    output logic         pc_predict_out,
    output fetch_state_e state_dbg
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         icache_req_q, icache_req_d;
    logic [31:0]  icache_addr_q, icache_addr_d;
    logic         instruction_ready_q, instruction_ready_d;
    logic [31:0]  instruction_out_q, instruction_out_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         pc_predict_out_q, pc_predict_out_d;

    logic [31:0]  pd_next_pc;
    logic         pd_predict;

    branch_predecoder u_predecoder (
        .instruction (icache_ins_in),
        .pc          (pc_q),
        .next_pc     (pd_next_pc),
        .predict     (pd_predict)
    );

    // Next state, next pc and registered outputs; redirect outranks everything but a pause.
    always_comb begin
        state_d             = state_q;
        pc_d                = pc_q;
        icache_req_d        = FALSE;
        icache_addr_d       = icache_addr_q;
        instruction_ready_d = FALSE;
        instruction_out_d   = instruction_out_q;
        pc_out_d            = pc_out_q;
        pc_predict_out_d    = pc_predict_out_q;

        if (rdy_in) begin
            if (roll_back) begin
                pc_d = target_pc_in;
                case (state_q)
                    FETCH:   state_d = FETCH;
                    WAIT:    state_d = icache_ready ? FETCH : DRAIN;
                    DRAIN:   state_d = DRAIN;
                    default: state_d = FETCH;
                endcase
            end else begin
                case (state_q)
                    FETCH: begin
                        if (!isq_is_full) begin
                            icache_req_d  = TRUE;
                            icache_addr_d = pc_q;
                            state_d       = WAIT;
                        end
                    end
                    WAIT: begin
                        if (icache_ready) begin
                            instruction_ready_d = TRUE;
                            instruction_out_d   = icache_ins_in;
                            pc_out_d            = pc_q;
                            pc_predict_out_d    = pd_predict;
                            pc_d                = pd_next_pc;
                            state_d             = FETCH;
                        end
                    end
                    DRAIN: begin
                        if (icache_ready) begin
                            state_d = FETCH;
                        end
                    end
                    default: state_d = FETCH;
                endcase
            end
        end
    end

    // State, pc and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q             <= FETCH;
            pc_q                <= 32'd0;
            icache_req_q        <= FALSE;
            icache_addr_q       <= 32'd0;
            instruction_ready_q <= FALSE;
            instruction_out_q   <= 32'd0;
            pc_out_q            <= 32'd0;
            pc_predict_out_q    <= FALSE;
        end else begin
            state_q             <= state_d;
            pc_q                <= pc_d;
            icache_req_q        <= icache_req_d;
            icache_addr_q       <= icache_addr_d;
            instruction_ready_q <= instruction_ready_d;
            instruction_out_q   <= instruction_out_d;
            pc_out_q            <= pc_out_d;
            pc_predict_out_q    <= pc_predict_out_d;
        end
    end

    assign icache_req        = icache_req_q;
    assign icache_addr       = icache_addr_q;
    assign instruction_ready = instruction_ready_q;
    assign instruction_out   = instruction_out_q;
    assign pc_out            = pc_out_q;
    assign pc_predict_out    = pc_predict_out_q;
    assign state_dbg         = state_q;

endmodule
